// File: rtl/icache_direct_if.sv
// ---------------------------------------------------------------------------
// icache_direct_if
// Bundles the fetch-side request/response handshake, the flush pulse and the
// instruction-memory refill bus of icache_direct.
//   slave  : the cache's view (takes i_* signals, drives o_* signals).
//   master : the environment's view (fetch unit + memory model).
// Fetch side : i_req_addr, i_req_bytemask, i_req_valid, i_resp_ready,
//              o_resp_data, o_resp_valid, o_req_ready, i_flush
// Memory side: o_mem_req, o_mem_addr, i_mem_gnt, i_mem_rvalid, i_mem_rdata
// ---------------------------------------------------------------------------
interface icache_direct_if;
  logic [31:0] i_req_addr;
  logic [3:0]  i_req_bytemask;
  logic        i_req_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_data;
  logic        o_resp_valid;
  logic        o_req_ready;
  logic        i_flush;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_req_addr, i_req_bytemask, i_req_valid, i_resp_ready, i_flush,
           i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_resp_data, o_resp_valid, o_req_ready, o_mem_req, o_mem_addr
  );

  modport master (
    output i_req_addr, i_req_bytemask, i_req_valid, i_resp_ready, i_flush,
           i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_resp_data, o_resp_valid, o_req_ready, o_mem_req, o_mem_addr
  );
endinterface

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
// Direct-mapped, read-only instruction cache. One fetch request per cycle is
// latched and answered in the following cycle on a hit. A miss refills the
// whole line with a WORDS-beat burst and then replays the held request.
// A flush pulse invalidates every line by walking them one per cycle.
// Ports:
//   i_clk  : clock
//   i_rstn : asynchronous active-low reset
//   bus    : icache_direct_if.slave (fetch handshake, flush, refill bus)
// ---------------------------------------------------------------------------
module icache_direct #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  icache_direct_if.slave bus
);
  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - WB - IB;

  typedef enum logic [1:0] {RUN, MISS_REQ, MISS_DATA, FLUSH} state_t;

  state_t           state_q;
  logic [31:0]      req_addr_q;
  logic             req_vld_q;
  logic [LINES-1:0] valid_q;
  logic [WB-1:0]    beat_cnt_q;
  logic [IB-1:0]    line_cnt_q;
  logic             flush_pend_q;

  // Tag and data storage carry no reset; only the valid bits do.
  logic [TB-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];

  logic [WB-1:0]    word_q;
  logic [IB-1:0]    idx_q;
  logic [TB-1:0]    tag_q;
  logic             hit;
  logic             miss;
  logic             req_ready;
  logic             accept;
  logic             fill_we;
  logic             fill_last;
  logic             resp_valid;

  assign word_q = req_addr_q[2 +: WB];
  assign idx_q  = req_addr_q[2+WB +: IB];
  assign tag_q  = req_addr_q[31 -: TB];

  assign hit       = req_vld_q & valid_q[idx_q] & (tag_mem[idx_q] == tag_q);
  assign miss      = req_vld_q & ~hit;
  assign req_ready = (state_q == RUN) & ~miss;
  assign accept    = bus.i_req_valid & bus.i_resp_ready & req_ready;

  // Beats are only taken in MISS_DATA; stray beats elsewhere are dropped.
  assign fill_we   = (state_q == MISS_DATA) & bus.i_mem_rvalid;
  assign fill_last = fill_we & (beat_cnt_q == WB'(WORDS - 1));

  assign resp_valid       = (state_q == RUN) & hit;
  assign bus.o_resp_valid = resp_valid;
  assign bus.o_resp_data  = resp_valid ? data_mem[idx_q][word_q] : 32'h0;
  assign bus.o_req_ready  = req_ready;
  assign bus.o_mem_req    = (state_q == MISS_REQ);
  assign bus.o_mem_addr   = (state_q == MISS_REQ) ? {tag_q, idx_q, {(WB+2){1'b0}}} : 32'h0;

  // Byte mask and the byte offset carry no information for word fetches.
  logic unused_ok;
  assign unused_ok = ^{bus.i_req_bytemask, req_addr_q[1:0]};

  always_ff @(posedge i_clk) begin
    if (fill_we) begin
      data_mem[idx_q][beat_cnt_q] <= bus.i_mem_rdata;
    end
    if (fill_last) begin
      tag_mem[idx_q] <= tag_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= RUN;
      req_addr_q   <= 32'h0;
      req_vld_q    <= 1'b0;
      valid_q      <= '0;
      beat_cnt_q   <= '0;
      line_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        req_addr_q <= bus.i_req_addr;
        req_vld_q  <= 1'b1;
      end
      case (state_q)
        RUN: begin
          // A pending miss takes priority; a coincident flush is remembered.
          if (miss) begin
            state_q      <= MISS_REQ;
            flush_pend_q <= bus.i_flush;
          end else if (bus.i_flush) begin
            state_q    <= FLUSH;
            line_cnt_q <= '0;
          end
        end
        MISS_REQ: begin
          if (bus.i_flush) flush_pend_q <= 1'b1;
          if (bus.i_mem_gnt) begin
            state_q    <= MISS_DATA;
            beat_cnt_q <= '0;
          end
        end
        MISS_DATA: begin
          if (bus.i_flush) flush_pend_q <= 1'b1;
          if (fill_we) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (fill_last) begin
              valid_q[idx_q] <= 1'b1;
              flush_pend_q   <= 1'b0;
              line_cnt_q     <= '0;
              state_q        <= (flush_pend_q | bus.i_flush) ? FLUSH : RUN;
            end
          end
        end
        FLUSH: begin
          valid_q[line_cnt_q] <= 1'b0;
          line_cnt_q          <= line_cnt_q + 1'b1;
          if (line_cnt_q == IB'(LINES - 1)) begin
            // The held request may refer to a now-stale line; drop it.
            req_vld_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
  logic clk;
  logic rstn;
  int   n_asserts;
  int   n_fail;

  icache_direct_if bus ();

  icache_direct #(.LINES(64), .WORDS(4)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic req(input logic [31:0] addr);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = addr;
    tick();
    bus.i_req_valid = 1'b0;
  endtask

  task automatic grant();
    bus.i_mem_gnt = 1'b1;
    tick();
    bus.i_mem_gnt = 1'b0;
  endtask

  task automatic beats(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = w[i];
      tick();
    end
    bus.i_mem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rvalid"}, 32'(bus.o_resp_valid), 32'd0);
    check({pfx, "_rdata"},  bus.o_resp_data,       32'h0);
    check({pfx, "_ready"},  32'(bus.o_req_ready),  32'd1);
    check({pfx, "_memreq"}, 32'(bus.o_mem_req),    32'd0);
    check({pfx, "_memaddr"}, bus.o_mem_addr,       32'h0);
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rstn               = 1'b0;
    bus.i_req_addr     = 32'h0;
    bus.i_req_bytemask = 4'hF;
    bus.i_req_valid    = 1'b0;
    bus.i_resp_ready   = 1'b1;
    bus.i_flush        = 1'b0;
    bus.i_mem_gnt      = 1'b0;
    bus.i_mem_rvalid   = 1'b0;
    bus.i_mem_rdata    = 32'h0;
    tick();
    tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Cold miss at 0x40
    req(32'h40);
    check("cold_rvalid", 32'(bus.o_resp_valid), 32'd0);
    check("cold_ready",  32'(bus.o_req_ready),  32'd0);
    check("cold_memreq0", 32'(bus.o_mem_req),   32'd0);
    tick();
    check("cold_memreq", 32'(bus.o_mem_req), 32'd1);
    check("cold_memaddr", bus.o_mem_addr,    32'h40);
    grant();
    check("cold_memreq_dn", 32'(bus.o_mem_req), 32'd0);
    beats(32'h13, 32'h93, 32'h113, 32'h193);
    check("cold_hit_v",    32'(bus.o_resp_valid), 32'd1);
    check("cold_hit_data", bus.o_resp_data,       32'h13);
    check("cold_hit_rdy",  32'(bus.o_req_ready),  32'd1);

    // Back-to-back hits
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h44; tick();
    check("hit44_v", 32'(bus.o_resp_valid), 32'd1);
    check("hit44_d", bus.o_resp_data, 32'h93);
    check("hit44_mr", 32'(bus.o_mem_req), 32'd0);
    bus.i_req_addr  = 32'h48; tick();
    check("hit48_v", 32'(bus.o_resp_valid), 32'd1);
    check("hit48_d", bus.o_resp_data, 32'h113);
    check("hit48_mr", 32'(bus.o_mem_req), 32'd0);
    bus.i_req_addr  = 32'h4C; tick();
    check("hit4C_v", 32'(bus.o_resp_valid), 32'd1);
    check("hit4C_d", bus.o_resp_data, 32'h193);
    check("hit4C_mr", 32'(bus.o_mem_req), 32'd0);
    bus.i_req_valid = 1'b0;
    tick();
    check("stall_v", 32'(bus.o_resp_valid), 32'd1);
    check("stall_d", bus.o_resp_data, 32'h193);

    // Conflict: 0x440 maps to index 4 with tag 1
    req(32'h440);
    check("conf_v", 32'(bus.o_resp_valid), 32'd0);
    tick();
    check("conf_memreq", 32'(bus.o_mem_req), 32'd1);
    check("conf_memaddr", bus.o_mem_addr, 32'h440);
    grant();
    beats(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    check("conf_hit_v", 32'(bus.o_resp_valid), 32'd1);
    check("conf_hit_d", bus.o_resp_data, 32'hA0);

    // 0x40 was evicted: miss with a grant held off for 5 cycles
    req(32'h40);
    check("evict_v",   32'(bus.o_resp_valid), 32'd0);
    check("evict_rdy", 32'(bus.o_req_ready),  32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("dly_memreq",  32'(bus.o_mem_req),    32'd1);
      check("dly_memaddr", bus.o_mem_addr,        32'h40);
      check("dly_ready",   32'(bus.o_req_ready),  32'd0);
      check("dly_rvalid",  32'(bus.o_resp_valid), 32'd0);
      tick();
    end
    grant();

    // Flush pulsed during MISS_DATA
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h13;  tick();
    bus.i_mem_rdata  = 32'h93;  bus.i_flush = 1'b1; tick();
    bus.i_flush      = 1'b0;
    bus.i_mem_rdata  = 32'h113; tick();
    bus.i_mem_rdata  = 32'h193; tick();
    bus.i_mem_rvalid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check("flush_ready",  32'(bus.o_req_ready),  32'd0);
      check("flush_rvalid", 32'(bus.o_resp_valid), 32'd0);
      tick();
    end
    check("postfl_ready",  32'(bus.o_req_ready),  32'd1);
    check("postfl_rvalid", 32'(bus.o_resp_valid), 32'd0);
    req(32'h40);
    check("postfl_miss_v", 32'(bus.o_resp_valid), 32'd0);
    check("postfl_miss_r", 32'(bus.o_req_ready),  32'd0);
    tick();
    check("postfl_memreq", 32'(bus.o_mem_req), 32'd1);
    check("postfl_maddr",  bus.o_mem_addr,     32'h40);

    // Reset in the middle of the burst
    grant();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h13; tick();
    bus.i_mem_rdata  = 32'h93; tick();
    bus.i_mem_rdata  = 32'h113;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rstn = 1'b1;
    tick();
    bus.i_mem_rvalid = 1'b0;
    check_reset_outputs("afterrst");
    req(32'h40);
    check("rst_miss_v", 32'(bus.o_resp_valid), 32'd0);
    check("rst_miss_r", 32'(bus.o_req_ready),  32'd0);
    tick();
    check("rst_memreq", 32'(bus.o_mem_req), 32'd1);
    grant();
    beats(32'h13, 32'h93, 32'h113, 32'h193);
    check("rst_hit_v", 32'(bus.o_resp_valid), 32'd1);
    check("rst_hit_d", bus.o_resp_data, 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the fetch unit's IMEM port and the instruction memory bus. It accepts one word request per cycle from fetch and returns the word one cycle later on a hit. On a miss it refills the whole line with a burst from memory and then replays the held request. It also supports a full invalidate (fence.i) by walking every line.

## Interface
Parameters:
- LINES, 64: number of cache lines; power of two, ≥2.
- WORDS, 4: 32-bit words per line; power of two, ≥2.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_req_addr  in  32  fetch address (byte address).
- i_req_bytemask  in  4  ignored; every access is a full word.
- i_req_valid  in  1  fetch presents a request.
- i_resp_ready  in  1  fetch can accept a response.
- o_resp_data  out  32  instruction word; 32'h0 whenever o_resp_valid=0.
- o_resp_valid  out  1  o_resp_data is valid for the held request.
- o_req_ready  out  1  cache can latch a new request this cycle.
- i_flush  in  1  one-cycle pulse that invalidates all lines.
- o_mem_req  out  1  line refill request; held until granted.
- o_mem_addr  out  32  line-aligned refill address.
- i_mem_gnt  in  1  memory accepts the request.
- i_mem_rvalid  in  1  refill beat valid.
- i_mem_rdata  in  32  refill beat data; words arrive in ascending order, word 0 first.

## Operation
- Address split:
  - bits [1:0] are ignored;
  - word = [2+log2(WORDS)-1:2];
  - index = next log2(LINES) bits;
  - tag = remaining upper bits.
  - Defaults: word [3:2], index [9:4], tag [31:10].
- Storage:
  - per line: valid bit, tag, WORDS×32 data (flop arrays);
  - only the valid bits are reset.
- Request register: when i_req_valid & i_resp_ready & o_req_ready, load req_addr_q ← i_req_addr and req_vld_q ← 1. Otherwise hold both.
- hit = req_vld_q & valid[index_q] & (tag[index_q] == tag_q).
- FSM states:
  - RUN: lookup.
    - hit → o_resp_valid=1, o_resp_data = data[index_q][word_q].
    - req_vld_q & ~hit → MISS_REQ.
    - i_flush (with no miss pending) → FLUSH.
  - MISS_REQ: o_mem_req=1, o_mem_addr = {tag_q, index_q, zeros}. Go to MISS_DATA on i_mem_gnt.
  - MISS_DATA: beat counter (log2(WORDS) bits, starts at 0).
    - Each i_mem_rvalid writes data[index_q][cnt] and increments cnt.
    - On the last beat, write tag and set valid, then go to RUN.
  - FLUSH: line counter from 0 to LINES-1, clearing one valid bit per cycle. On the last line, clear req_vld_q and go to RUN.
- o_req_ready = (state==RUN) & ~(req_vld_q & ~hit).
- i_flush arriving in MISS_REQ/MISS_DATA sets flush_pend. The refill completes, then the FSM enters FLUSH instead of RUN. In RUN, a simultaneous miss and i_flush sends the FSM to MISS_REQ with flush_pend set.
- i_mem_rvalid outside MISS_DATA is ignored.
- No error reporting; fetch checks alignment.

## Timing
- Reset values:
  - state=RUN; req_vld_q=0; all valid bits cleared; counters=0; flush_pend=0.
  - o_resp_valid=0, o_resp_data=0, o_req_ready=1, o_mem_req=0, o_mem_addr=0.
- Hit latency: request accepted at edge N gives o_resp_valid=1 during cycle N+1. Back-to-back hits sustain 1 word/cycle.
- Miss:
  - cycle N+1: o_resp_valid=0, o_req_ready=0;
  - cycle N+2: MISS_REQ, o_mem_req=1;
  - after the gnt edge: WORDS beats;
  - the cycle after the last-beat edge: RUN, hit on the held address, o_resp_valid=1 and o_req_ready=1.
- Refill penalty with gnt in its first cycle and back-to-back beats: 3+WORDS cycles.
- FLUSH lasts exactly LINES cycles. o_req_ready=0 throughout. The first cycle after FLUSH has o_resp_valid=0.
- Holding i_req_valid=0 keeps req_q: a stalled fetch sees the same response every cycle.
- Asynchronous reset mid-refill aborts the burst. Any beats still in flight are discarded, since they arrive outside MISS_DATA.

## Test plan
- Cold miss at 0x0000_0040: o_mem_addr=0x40; return beats 0x13,0x93,0x113,0x193 → RUN cycle gives o_resp_data=0x13, valid=1, ready=1.
- Request 0x44,0x48,0x4C back to back after the above → three consecutive hits returning 0x93,0x113,0x193 with no o_mem_req.
- Conflict: 0x40 then 0x440 (same index 4, tag 1) → refill evicts the line; a subsequent 0x40 misses again.
- Grant delayed 5 cycles → o_mem_req and o_mem_addr stable all 5 cycles; o_req_ready=0; o_resp_valid=0.
- i_flush pulsed during MISS_DATA → refill completes, FLUSH lasts 64 cycles, then 0x40 misses again.
- Reset asserted mid-burst → all outputs return to reset values; the next request misses.
